// File: rtl/psychic5_video_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// psychic5_video_pkg : shared timing defaults, CRC constants and CRC helper
// Revision: 1.0
// ---------------------------------------------------------------------------
package psychic5_video_pkg;

  localparam logic [8:0] H_ACT_START_DEF = 9'd136;
  localparam logic [8:0] H_ACT_END_DEF   = 9'd392;
  localparam logic [8:0] HS_START_DEF    = 9'd424;
  localparam logic [8:0] HS_END_DEF      = 9'd456;
  localparam logic [8:0] V_ACT_START_DEF = 9'd272;
  localparam logic [8:0] V_ACT_END_DEF   = 9'd496;
  localparam logic [8:0] VS_START_DEF    = 9'd504;
  localparam logic [8:0] VS_END_DEF      = 9'd507;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [0:0] {
    FRAME_IDLE   = 1'b0,
    FRAME_ACTIVE = 1'b1
  } frame_state_t;

  // CRC-16-CCITT, 12 data bits folded MSB first, no reflection.
  function automatic logic [15:0] crc16_step12(input logic [15:0] crc,
                                               input logic [11:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 11; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/psychic5_video_out_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// psychic5_video_out_if : video-in / re-timed video-out bundle
// Revision: 1.0
// ---------------------------------------------------------------------------
interface psychic5_video_out_if;
  logic        pix_ce_n;
  logic [8:0]  hcounter;
  logic [8:0]  vcounter;
  logic [11:0] video_rgb;
  logic [3:0]  video_r;
  logic [3:0]  video_g;
  logic [3:0]  video_b;
  logic        hblank;
  logic        vblank;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [15:0] frame_crc;
  logic        frame_done;
  logic [15:0] frame_count;

  modport master (
    output pix_ce_n, hcounter, vcounter, video_rgb,
    input  video_r, video_g, video_b, hblank, vblank, hsync, vsync, de,
           frame_crc, frame_done, frame_count
  );

  modport slave (
    input  pix_ce_n, hcounter, vcounter, video_rgb,
    output video_r, video_g, video_b, hblank, vblank, hsync, vsync, de,
           frame_crc, frame_done, frame_count
  );
endinterface
`default_nettype wire

// File: rtl/psychic5_frame_crc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// psychic5_frame_crc : per-frame CRC of active pixels, frame FSM and counters
// Revision: 1.0
// ---------------------------------------------------------------------------
module psychic5_frame_crc
  import psychic5_video_pkg::*;
#(
  parameter logic [8:0] H_ACT_START = H_ACT_START_DEF,
  parameter logic [8:0] V_ACT_START = V_ACT_START_DEF,
  parameter logic [8:0] V_ACT_END   = V_ACT_END_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [8:0]  hcounter,
  input  logic [8:0]  vcounter,
  input  logic [11:0] rgb,
  input  logic        pix_active,
  output logic [15:0] frame_crc,
  output logic        frame_done,
  output logic [15:0] frame_count
);

  frame_state_t state;
  frame_state_t state_nxt;
  logic         frame_start;
  logic         frame_end;
  logic [15:0]  acc;

  assign frame_start = tick && (vcounter == V_ACT_START) && (hcounter == H_ACT_START);

  always_ff @(posedge clk) begin
    if (rst) state <= FRAME_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    frame_end = 1'b0;
    if (frame_start) begin
      state_nxt = FRAME_ACTIVE;
    end else if (state == FRAME_ACTIVE && tick &&
                 vcounter == V_ACT_END && hcounter == H_ACT_START) begin
      state_nxt = FRAME_IDLE;
      frame_end = 1'b1;
    end
  end

  // A frame start always reloads, which also covers a restart while ACTIVE.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= CRC16_INIT;
      frame_crc   <= 16'h0000;
      frame_done  <= 1'b0;
      frame_count <= 16'h0000;
    end else begin
      frame_done <= frame_end;
      if (frame_start)
        acc <= crc16_step12(CRC16_INIT, rgb);
      else if (state == FRAME_ACTIVE && tick && pix_active)
        acc <= crc16_step12(acc, rgb);
      if (frame_end) begin
        frame_crc   <= acc;
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/psychic5_video_out.sv
`default_nettype none
// ---------------------------------------------------------------------------
// psychic5_video_out : re-times Psychic5 video, decodes blank/sync, frame CRC
// Revision: 1.0
// ---------------------------------------------------------------------------
module psychic5_video_out
  import psychic5_video_pkg::*;
#(
  parameter logic [8:0] H_ACT_START = H_ACT_START_DEF,
  parameter logic [8:0] H_ACT_END   = H_ACT_END_DEF,
  parameter logic [8:0] HS_START    = HS_START_DEF,
  parameter logic [8:0] HS_END      = HS_END_DEF,
  parameter logic [8:0] V_ACT_START = V_ACT_START_DEF,
  parameter logic [8:0] V_ACT_END   = V_ACT_END_DEF,
  parameter logic [8:0] VS_START    = VS_START_DEF,
  parameter logic [8:0] VS_END      = VS_END_DEF
) (
  input  logic               clk,
  input  logic               rst,
  psychic5_video_out_if.slave vid
);

  logic        tick;
  logic        hact;
  logic        vact;
  logic        hs;
  logic        vs;
  logic [11:0] rgb_q;
  logic        hblank_q;
  logic        vblank_q;
  logic        hsync_q;
  logic        vsync_q;
  logic [15:0] crc;
  logic        done;
  logic [15:0] count;

  assign tick = ~vid.pix_ce_n;
  assign hact = (vid.hcounter >= H_ACT_START) && (vid.hcounter < H_ACT_END);
  assign vact = (vid.vcounter >= V_ACT_START) && (vid.vcounter < V_ACT_END);
  assign hs   = (vid.hcounter >= HS_START)    && (vid.hcounter < HS_END);
  assign vs   = (vid.vcounter >= VS_START)    && (vid.vcounter < VS_END);

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q    <= 12'h000;
      hblank_q <= 1'b1;
      vblank_q <= 1'b1;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
    end else if (tick) begin
      rgb_q    <= (hact && vact) ? vid.video_rgb : 12'h000;
      hblank_q <= ~hact;
      vblank_q <= ~vact;
      hsync_q  <= hs;
      vsync_q  <= vs;
    end
  end

  assign vid.video_r     = rgb_q[11:8];
  assign vid.video_g     = rgb_q[7:4];
  assign vid.video_b     = rgb_q[3:0];
  assign vid.hblank      = hblank_q;
  assign vid.vblank      = vblank_q;
  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.de          = ~(hblank_q | vblank_q);
  assign vid.frame_crc   = crc;
  assign vid.frame_done  = done;
  assign vid.frame_count = count;

  psychic5_frame_crc #(
    .H_ACT_START (H_ACT_START),
    .V_ACT_START (V_ACT_START),
    .V_ACT_END   (V_ACT_END)
  ) u_frame_crc (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .hcounter    (vid.hcounter),
    .vcounter    (vid.vcounter),
    .rgb         (vid.video_rgb),
    .pix_active  (hact && vact),
    .frame_crc   (crc),
    .frame_done  (done),
    .frame_count (count)
  );

endmodule
`default_nettype wire

// File: tb/tb_psychic5_video_out.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_psychic5_video_out : scoreboard bench for psychic5_video_out
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_psychic5_video_out;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  psychic5_video_out_if vid();

  psychic5_video_out dut (
    .clk (clk),
    .rst (rst),
    .vid (vid)
  );

  typedef struct packed {
    logic [11:0] rgb;
    logic        hb;
    logic        vb;
    logic        hs;
    logic        vs;
    logic        de;
    logic        done;
    logic [15:0] crc;
    logic [15:0] count;
  } exp_t;

  exp_t        q[$];
  exp_t        reset_exp;
  exp_t        last;
  int          checks   = 0;
  int          failures = 0;
  int          done_seen = 0;
  logic [15:0] done_crc[$];

  // reference model state
  bit          m_active;
  logic [15:0] m_acc;
  logic [15:0] m_crc;
  logic [15:0] m_count;
  int          gap = 1;

  int hc_list[11] = '{0, 135, 136, 137, 200, 255, 391, 392, 424, 455, 460};
  int vc_list[6]  = '{271, 272, 273, 300, 400, 495};
  int hb_list[8]  = '{135, 136, 391, 392, 423, 424, 455, 456};
  int vb_list[4]  = '{503, 504, 506, 507};

  function automatic logic [15:0] ref_crc(input logic [15:0] crc, input logic [11:0] d);
    logic [15:0] r;
    r = crc;
    for (int k = 0; k < 12; k++) begin
      if (r[15] ^ d[11-k]) r = (r << 1) ^ 16'h1021;
      else                 r = r << 1;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare(input string pfx, input exp_t e);
    check({pfx, "_video"}, {36'd0, vid.video_r, vid.video_g, vid.video_b}, {36'd0, e.rgb});
    check({pfx, "_timing"}, {43'd0, vid.hblank, vid.vblank, vid.hsync, vid.vsync, vid.de},
          {43'd0, e.hb, e.vb, e.hs, e.vs, e.de});
    check({pfx, "_frame"}, {15'd0, vid.frame_done, vid.frame_crc, vid.frame_count},
          {15'd0, e.done, e.crc, e.count});
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_acc    = 16'hFFFF;
    m_crc    = 16'h0000;
    m_count  = 16'h0000;
  endtask

  task automatic pix(input int hc, input int vc, input logic [11:0] rgb);
    exp_t e;
    bit ha, va, st, en;
    repeat (gap - 1) begin
      @(negedge clk);
      vid.pix_ce_n = 1'b1;
    end
    @(negedge clk);
    vid.pix_ce_n  = 1'b0;
    vid.hcounter  = hc[8:0];
    vid.vcounter  = vc[8:0];
    vid.video_rgb = rgb;
    ha = (hc >= 136) && (hc < 392);
    va = (vc >= 272) && (vc < 496);
    e.rgb = (ha && va) ? rgb : 12'h000;
    e.hb  = !ha;
    e.vb  = !va;
    e.hs  = (hc >= 424) && (hc < 456);
    e.vs  = (vc >= 504) && (vc < 507);
    e.de  = ha && va;
    st = (vc == 272) && (hc == 136);
    en = !st && m_active && (vc == 496) && (hc == 136);
    if (st) begin
      m_acc    = ref_crc(16'hFFFF, rgb);
      m_active = 1'b1;
    end else if (en) begin
      m_crc    = m_acc;
      m_count  = m_count + 16'd1;
      m_active = 1'b0;
    end else if (m_active && ha && va) begin
      m_acc = ref_crc(m_acc, rgb);
    end
    e.done  = en;
    e.crc   = m_crc;
    e.count = m_count;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      vid.pix_ce_n = 1'b1;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    vid.pix_ce_n = 1'b0;
    repeat (n - 1) @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    vid.pix_ce_n = 1'b1;
    model_reset();
  endtask

  // One compressed frame: a subset of lines/pixels, then the end-of-frame tick.
  task automatic frame(input bit alt, input bit rst_mid);
    logic [11:0] c;
    foreach (vc_list[i]) begin
      foreach (hc_list[j]) begin
        c = (alt && vc_list[i] == 400 && hc_list[j] == 200) ? 12'h123 : 12'h5A3;
        pix(hc_list[j], vc_list[i], c);
        if (rst_mid && vc_list[i] == 400 && hc_list[j] == 200) do_reset(2);
      end
    end
    pix(0, 496, 12'h5A3);
    pix(136, 496, 12'h5A3);
    pix(136, 505, 12'h5A3);
  endtask

  // Monitor: compares every MCLK edge against reset values, a scoreboard entry or the held state.
  initial begin
    bit   s_rst, s_tick;
    exp_t e;
    forever begin
      @(posedge clk);
      s_rst  = rst;
      s_tick = !vid.pix_ce_n;
      #1;
      if (s_rst) begin
        compare("reset", reset_exp);
        last = reset_exp;
      end else if (s_tick) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_underflow actual=empty required=entry at %0t", $time);
        end else begin
          e = q.pop_front();
          compare("tick", e);
          last = e;
        end
      end else begin
        last.done = 1'b0;
        compare("hold", last);
      end
      if (vid.frame_done === 1'b1) begin
        done_seen++;
        done_crc.push_back(vid.frame_crc);
      end
    end
  end

  initial begin
    reset_exp = '{rgb: 12'h000, hb: 1'b1, vb: 1'b1, hs: 1'b0, vs: 1'b0, de: 1'b0,
                  done: 1'b0, crc: 16'h0000, count: 16'h0000};
    last = reset_exp;
    vid.pix_ce_n  = 1'b0;
    vid.hcounter  = 9'd0;
    vid.vcounter  = 9'd0;
    vid.video_rgb = 12'h000;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    vid.pix_ce_n = 1'b1;

    foreach (hb_list[i]) pix(hb_list[i], 300, 12'h777);
    foreach (vb_list[i]) pix(200, vb_list[i], 12'h777);
    pix(130, 300, 12'hFFF);
    pix(200, 300, 12'hABC);
    idle(2);

    // aborted start, then three frames; the third differs by one pixel
    pix(136, 272, 12'hFFF);
    pix(137, 272, 12'h001);
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    frame(1'b1, 1'b0);
    idle(3);
    check("done_pulses_3", done_seen, 3);
    check("count_3", {32'd0, vid.frame_count}, 48'd3);
    checks++;
    if (done_crc.size() < 3) begin
      failures++;
      $display("FAIL crc_frames actual=%0d required=3", done_crc.size());
    end else begin
      check("crc_f1_eq_f2", {32'd0, done_crc[1]}, {32'd0, done_crc[0]});
      checks++;
      if (done_crc[2] === done_crc[1]) begin
        failures++;
        $display("FAIL crc_f3_differs actual=%h required=not_%h", done_crc[2], done_crc[1]);
      end
    end

    frame(1'b0, 1'b1);
    idle(3);
    check("no_done_after_mid_reset", done_seen, 3);
    frame(1'b0, 1'b0);
    idle(3);
    check("count_after_reset", {32'd0, vid.frame_count}, 48'd1);

    gap = 2;
    frame(1'b0, 1'b0);
    gap = 5;
    frame(1'b0, 1'b0);
    gap = 1;
    idle(3);
    check("count_after_gaps", {32'd0, vid.frame_count}, 48'd3);
    checks++;
    if (done_crc.size() != 6) begin
      failures++;
      $display("FAIL done_total actual=%0d required=6", done_crc.size());
    end else begin
      check("crc_after_reset", {32'd0, done_crc[3]}, {32'd0, done_crc[0]});
      check("crc_gap2", {32'd0, done_crc[4]}, {32'd0, done_crc[0]});
      check("crc_gap5", {32'd0, done_crc[5]}, {32'd0, done_crc[0]});
    end
    check("scoreboard_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
